// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: ALU and load producers in, register-file write port and load-queue status out.
interface writeback_arbiter_if;
    logic        aluValid;
    logic [4:0]  aluRegister;
    logic [31:0] aluData;
    logic        memValid;
    logic        memReady;
    logic [4:0]  memRegister;
    logic [31:0] memData;
    logic        writeEnable;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [2:0]  bufferCount;

    // Load handshake: a load transfers when memValid && memReady at a rising edge;
    // memValid may be raised without waiting for memReady. ALU results are never stalled.
    modport slave (
        input  aluValid, aluRegister, aluData,
        input  memValid, memRegister, memData,
        output memReady,
        output writeEnable, writeRegister, writeData,
        output bufferCount
    );

    modport master (
        output aluValid, aluRegister, aluData,
        output memValid, memRegister, memData,
        input  memReady,
        input  writeEnable, writeRegister, writeData,
        input  bufferCount
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Single register-file write port shared by ALU results (priority) and a 4-entry load queue.
// Optional macro WB_BYPASS_EN lets a load skip the empty queue when the port is idle.
module writeback_arbiter (
    input  logic              clk,
    input  logic              rst,
    writeback_arbiter_if.slave wb
);
    localparam int DEPTH = 4;

    logic [4:0]       reg_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [2:0]       count_q, count_d;

    logic             we_q, we_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [31:0]      wdata_q, wdata_d;

    logic             accept, bypass, enq, deq, enq_live;
    logic [DEPTH-1:0] kill;

    // memReady depends only on the registered count, so a full queue refuses a load
    // even in a cycle where the head drains.
    assign wb.memReady      = (count_q < 3'd4);
    assign wb.writeEnable   = we_q;
    assign wb.writeRegister = wreg_q;
    assign wb.writeData     = wdata_q;
    assign wb.bufferCount   = count_q;

    always_comb begin
        accept = wb.memValid && (count_q < 3'd4);
        bypass = 1'b0;
`ifdef WB_BYPASS_EN
        bypass = accept && !wb.aluValid && (count_q == 3'd0);
`else
        bypass = 1'b0;
`endif
        enq = accept && !bypass;
        deq = !wb.aluValid && (count_q != 3'd0);
        // A same-cycle ALU write to the same register is program-younger than the load.
        enq_live = !(wb.aluValid && (wb.aluRegister == wb.memRegister));

        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = wb.aluValid && (wb.aluRegister != 5'd0) && (reg_q[i] == wb.aluRegister);
        end

        live_d = live_q & ~kill;
        if (deq) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (enq) begin
            live_d[wr_ptr_q] = enq_live;
        end

        rd_ptr_d = deq ? rd_ptr_q + 2'd1 : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + 2'd1 : wr_ptr_q;
        count_d  = count_q + {2'b00, enq} - {2'b00, deq};

        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (wb.aluValid) begin
            we_d    = (wb.aluRegister != 5'd0);
            wreg_d  = wb.aluRegister;
            wdata_d = wb.aluData;
        end else if (deq) begin
            we_d    = live_q[rd_ptr_q] && (reg_q[rd_ptr_q] != 5'd0);
            wreg_d  = reg_q[rd_ptr_q];
            wdata_d = data_q[rd_ptr_q];
        end else if (bypass) begin
            we_d    = (wb.memRegister != 5'd0);
            wreg_d  = wb.memRegister;
            wdata_d = wb.memData;
        end
        // Address/data only move on a real write; a suppressed slot leaves them untouched.
        if (!we_d) begin
            wreg_d  = wreg_q;
            wdata_d = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            if (enq) begin
                reg_q[wr_ptr_q]  <= wb.memRegister;
                data_q[wr_ptr_q] <= wb.memData;
            end
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_writeback_arbiter;
    logic clk;
    logic rst;

    writeback_arbiter_if wb ();

    writeback_arbiter dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic set_idle();
        wb.aluValid    = 1'b0;
        wb.aluRegister = '0;
        wb.aluData     = '0;
        wb.memValid    = 1'b0;
        wb.memRegister = '0;
        wb.memData     = '0;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        wb.aluValid    = v;
        wb.aluRegister = r;
        wb.aluData     = d;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] r, input logic [31:0] d);
        wb.memValid    = v;
        wb.memRegister = r;
        wb.memData     = d;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_we   = 1'b0;
        exp_reg  = '0;
        exp_data = '0;
    endtask

    // Model one clock: ALU owns the port, otherwise the oldest queued load, otherwise
    // (bypass builds) a fresh load into an empty queue. Then advance past the edge.
    task automatic tick();
        logic acc;
        logic byp;
        ent_t e;
        acc = wb.memValid && (mq.size() < 4);
        byp = 1'b0;
        exp_we = 1'b0;
        if (wb.aluValid) begin
            if (wb.aluRegister != 0) begin
                exp_we   = 1'b1;
                exp_reg  = wb.aluRegister;
                exp_data = wb.aluData;
                foreach (mq[i]) if (mq[i].r == wb.aluRegister) mq[i].live = 1'b0;
            end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.live && e.r != 0) begin
                exp_we   = 1'b1;
                exp_reg  = e.r;
                exp_data = e.d;
            end
        end else if (BYPASS && acc) begin
            byp = 1'b1;
            if (wb.memRegister != 0) begin
                exp_we   = 1'b1;
                exp_reg  = wb.memRegister;
                exp_data = wb.memData;
            end
        end
        if (acc && !byp) begin
            e.r    = wb.memRegister;
            e.d    = wb.memData;
            e.live = !(wb.aluValid && wb.aluRegister == wb.memRegister);
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_idle();
        model_reset();
        #3;
        n_tests++;
        if ({wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount, wb.memReady} !==
            {1'b0, 5'd0, 32'd0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values we=%b reg=%0d data=%h cnt=%0d rdy=%b, need 0 0 0 0 1",
                     wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount, wb.memReady);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        n_tests++;
        if (wb.memReady !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got=%b need=1", wb.memReady);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_priority();
        set_alu(1'b1, 5'd5, 32'h0D15EA5E);
        set_mem(1'b1, 5'd7, 32'h50D1EB0B);
        tick();
        set_idle();
        n_tests++;
        if ({wb.writeEnable, wb.writeRegister, wb.writeData} !== {1'b1, 5'd5, 32'h0D15EA5E}) begin
            n_fail++;
            $display("FAIL priority_alu we=%b reg=%0d data=%h need 1 5 0d15ea5e",
                     wb.writeEnable, wb.writeRegister, wb.writeData);
        end
        tick();
        n_tests++;
        if ({wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount} !==
            {1'b1, 5'd7, 32'h50D1EB0B, 3'd0}) begin
            n_fail++;
            $display("FAIL priority_load we=%b reg=%0d data=%h cnt=%0d need 1 7 50d1eb0b 0",
                     wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_alu(1'b1, 5'd1, 32'hA000_0000 + i);
            set_mem(1'b1, 5'(10 + i), 32'hB000_0000 + i);
            tick();
        end
        n_tests++;
        if ({wb.bufferCount, wb.memReady} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL full_state cnt=%0d rdy=%b need 4 0", wb.bufferCount, wb.memReady);
        end
        set_mem(1'b1, 5'd14, 32'hB000_0004);
        tick();
        n_tests++;
        if ({wb.bufferCount, wb.memReady} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL full_holdoff cnt=%0d rdy=%b need 4 0", wb.bufferCount, wb.memReady);
        end
        set_idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ({wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount, wb.memReady} !==
                {1'b1, 5'(10 + i), 32'hB000_0000 + i, 3'(3 - i), 1'b1}) begin
                n_fail++;
                $display("FAIL full_drain%0d we=%b reg=%0d data=%h cnt=%0d rdy=%b need 1 %0d %h %0d 1",
                         i, wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount,
                         wb.memReady, 10 + i, 32'hB000_0000 + i, 3 - i);
            end
        end
    endtask

    task automatic test_kill();
        set_alu(1'b1, 5'd20, 32'h2020_2020);
        set_mem(1'b1, 5'd3, 32'hFFFF_FFFF);
        tick();
        set_alu(1'b1, 5'd3, 32'h0000_0001);
        set_mem(1'b0, 5'd0, 32'h0);
        tick();
        n_tests++;
        if ({wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount} !==
            {1'b1, 5'd3, 32'h1, 3'd1}) begin
            n_fail++;
            $display("FAIL kill_alu we=%b reg=%0d data=%h cnt=%0d need 1 3 00000001 1",
                     wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount);
        end
        set_idle();
        tick();
        n_tests++;
        if ({wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount} !==
            {1'b0, 5'd3, 32'h1, 3'd0}) begin
            n_fail++;
            $display("FAIL kill_dequeue we=%b reg=%0d data=%h cnt=%0d need 0 3 00000001 0",
                     wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount);
        end
    endtask

    task automatic test_reg0();
        set_alu(1'b1, 5'd0, 32'hDEAD_BEEF);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);
        set_mem(1'b1, 5'd0, 32'hDEAD_BEEF);
        n_tests++;
        if (wb.writeEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL reg0_alu we=%b need 0", wb.writeEnable);
        end
        tick();
        set_idle();
        tick();
        tick();
        n_tests++;
        if ({wb.writeEnable, wb.bufferCount} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reg0_load we=%b cnt=%0d need 0 0", wb.writeEnable, wb.bufferCount);
        end
    endtask

    task automatic test_bypass();
        set_mem(1'b1, 5'd9, 32'h1234_5678);
        tick();
        set_idle();
        n_tests++;
        if ({wb.writeEnable, wb.bufferCount} !== (BYPASS ? {1'b1, 3'd0} : {1'b0, 3'd1})) begin
            n_fail++;
            $display("FAIL bypass_edge1 we=%b cnt=%0d bypass=%0d", wb.writeEnable, wb.bufferCount, BYPASS);
        end
        if (BYPASS) begin
            n_tests++;
            if ({wb.writeRegister, wb.writeData} !== {5'd9, 32'h1234_5678}) begin
                n_fail++;
                $display("FAIL bypass_data reg=%0d data=%h need 9 12345678", wb.writeRegister, wb.writeData);
            end
        end
        tick();
        n_tests++;
        if (BYPASS ? (wb.writeEnable !== 1'b0) :
            ({wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount} !==
             {1'b1, 5'd9, 32'h1234_5678, 3'd0})) begin
            n_fail++;
            $display("FAIL bypass_edge2 we=%b reg=%0d data=%h cnt=%0d bypass=%0d",
                     wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount, BYPASS);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            set_alu($urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom);
            set_mem($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
            n_tests++;
            if (wb.memReady !== (mq.size() < 4)) begin
                n_fail++;
                errs++;
                $display("FAIL random_ready c=%0d got=%b need=%b", c, wb.memReady, mq.size() < 4);
            end
            tick();
            n_tests++;
            if ({wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount} !==
                {exp_we, exp_reg, exp_data, 3'(mq.size())}) begin
                n_fail++;
                errs++;
                if (errs < 10)
                    $display("FAIL random_out c=%0d got we=%b reg=%0d data=%h cnt=%0d need %b %0d %h %0d",
                             c, wb.writeEnable, wb.writeRegister, wb.writeData, wb.bufferCount,
                             exp_we, exp_reg, exp_data, mq.size());
            end
        end
        set_idle();
        for (int c = 0; c < 5; c++) tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_alu(1'b1, 5'd2, 32'hC0DE_0000 + i);
            set_mem(1'b1, 5'(16 + i), 32'hF00D_0000 + i);
            tick();
        end
        set_idle();
        n_tests++;
        if (wb.bufferCount !== 3'd3) begin
            n_fail++;
            $display("FAIL midreset_fill cnt=%0d need 3", wb.bufferCount);
        end
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({wb.writeEnable, wb.bufferCount, wb.memReady} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_async we=%b cnt=%0d rdy=%b need 0 0 1",
                     wb.writeEnable, wb.bufferCount, wb.memReady);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_tests++;
            if ({wb.writeEnable, wb.bufferCount} !== {1'b0, 3'd0}) begin
                n_fail++;
                $display("FAIL midreset_nowrite c=%0d we=%b cnt=%0d need 0 0",
                         c, wb.writeEnable, wb.bufferCount);
            end
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_full();
        test_kill();
        test_reg0();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Reset is asynchronous and active-low; the block has a single clock.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 aluValid  input  1  ALU result present this cycle; no backpressure, always accepted.
REQ-005 aluRegister  input  5  ALU destination register.
REQ-006 aluData  input  32  ALU result.
REQ-007 memValid  input  1  load result offered.
REQ-008 memReady  output  1  load result accepted when memValid&&memReady at rising edge.
REQ-009 memRegister  input  5  load destination register.
REQ-010 memData  input  32  load result.
REQ-011 writeEnable  output  1  registered write strobe to register_file.
REQ-012 writeRegister  output  5  registered write address to register_file.
REQ-013 writeData  output  32  registered write data to register_file.
REQ-014 bufferCount  output  3  occupied load-queue entries, 0..4.

Function
REQ-015 Load queue SHALL be a 4-entry FIFO of {register, data, live}; bufferCount = occupancy.
REQ-016 memReady SHALL equal (bufferCount < 4), purely from registered count; no enqueue when full even if a dequeue occurs that cycle.
REQ-017 Arbitration per cycle: aluValid wins the write port; else, if queue non-empty, head entry dequeued.
REQ-018 Output latency SHALL be 1 cycle: winner registered onto writeEnable/writeRegister/writeData at next rising edge.
REQ-019 A write to register 0 (either source) SHALL produce writeEnable=0; a register-0 load is still dequeued.
REQ-020 A dequeued entry with live=0 SHALL produce writeEnable=0 that cycle (slot consumed, no write).
REQ-021 ALU write to register R (R!=0) SHALL clear live on every queued entry with register R in the same edge.
REQ-022 A load enqueued in the same cycle as an ALU write to the same register SHALL be enqueued with live=0 (ALU result is program-younger).
REQ-023 When writeEnable=0, writeRegister/writeData SHALL hold their previous values.
REQ-024 Read/write pointers SHALL wrap modulo 4; simultaneous enqueue and dequeue SHALL leave bufferCount unchanged.
REQ-025 Minimum load-to-write latency without bypass: 2 cycles (enqueue edge, then dequeue/output edge).

Reset
REQ-026 On rst=0, asynchronously: writeEnable=0, writeRegister=0, writeData=0, bufferCount=0, pointers=0, all live=0.
REQ-027 memReady SHALL be 1 during and immediately after reset.
REQ-028 Reset mid-operation SHALL discard all queued loads; no write issued for discarded entries.
REQ-029 First accepted transfer is on the first rising edge with rst=1.

Configuration
REQ-030 Macro WB_BYPASS_EN: when defined, a load arriving with queue empty and aluValid=0 SHALL bypass the FIFO and be written at the next edge (1-cycle latency, bufferCount stays 0).
REQ-031 Without WB_BYPASS_EN, every load SHALL pass through the FIFO (REQ-025 latency); all other behaviour identical.

Verification
REQ-032 Reset: rst=0 with queue holding 3 entries -> writeEnable=0, bufferCount=0, memReady=1 immediately, no later write from those entries.
REQ-033 Priority: aluValid=1 reg5 0x0D15EA5E and memValid=1 reg7 0x50D1EB0B same cycle -> next edge write reg5 0x0D15EA5E; reg7 written one cycle later (no bypass).
REQ-034 Full: 4 loads with aluValid held 1 -> bufferCount=4, memReady=0, 5th load held off; drop aluValid -> 4 writes on 4 consecutive cycles, memReady=1 after first dequeue.
REQ-035 Kill: queue load reg3 0xFFFFFFFF, then ALU write reg3 0x00000001 -> reg3 written once with 0x00000001; dequeue of the load gives writeEnable=0.
REQ-036 Register 0: ALU or load to reg0 0xDEADBEEF -> writeEnable stays 0; load still leaves the queue.
REQ-037 Bypass: with WB_BYPASS_EN, idle queue, load reg9 0x12345678 -> write at next edge, bufferCount=0; without macro -> write two edges after acceptance.
